button_event_queue: RTL and testbench

//  Memory-mapped responder for processor button reads at dmem address 7. Debounces the four

---
 rtl/btn_pkg.sv | 40 ++++
 rtl/btn_debounce.sv | 50 +++++
 rtl/button_event_queue.sv | 149 ++++++++++++++
 tb/tb_button_event_queue.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared button-event definitions: colour codes and event/word bit positions.
// Used by the button queue, the light_up driver and the audio driver.
package btn_pkg;

  localparam logic [1:0] COLOR_RED    = 2'b00;
  localparam logic [1:0] COLOR_BLUE   = 2'b01;
  localparam logic [1:0] COLOR_GREEN  = 2'b10;
  localparam logic [1:0] COLOR_YELLOW = 2'b11;

  // Bit positions inside the 32-bit word returned to the processor.
  localparam int unsigned BTN_EVT_VALID_BIT = 2;
  localparam int unsigned BTN_EVT_REL_BIT   = 3;

  // Queued event: {rel, colour[1:0]}.
  localparam int unsigned BTN_EVT_W = 3;
  typedef logic [BTN_EVT_W-1:0] btn_evt_t;

  // Map an arbiter slot (0..3) onto its colour code.
  function automatic logic [1:0] colour_of(input logic [1:0] slot);
    logic [1:0] c;
    case (slot)
      2'd0:    c = COLOR_RED;
      2'd1:    c = COLOR_BLUE;
      2'd2:    c = COLOR_GREEN;
      default: c = COLOR_YELLOW;
    endcase
    return c;
  endfunction

  // Expand a queued event into the processor read word.
  function automatic logic [31:0] evt_word(input btn_evt_t e);
    logic [31:0] w;
    w                    = '0;
    w[1:0]               = e[1:0];
    w[BTN_EVT_VALID_BIT] = 1'b1;
    w[BTN_EVT_REL_BIT]   = e[2];
    return w;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-button conditioner: 2-flop synchroniser, stability counter and
// accepted (stable) level with one-cycle rise/fall pulses on each accepted change.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic button,
  output logic stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  // Synchronise, count consecutive disagreeing cycles, flip the stable level at the limit.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      cnt        <= '0;
      stable     <= 1'b0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      sync1      <= button;
      sync2      <= sync1;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_MAX) begin
          stable     <= sync2;
          cnt        <= '0;
          rise_pulse <= sync2;
          fall_pulse <= ~sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/button_event_queue.sv
// Memory-mapped button event queue (processor read at dmem address 7).
// Debounces four buttons, arbitrates pending press events into a FIFO and
// pops one event per rising edge of poll.
// Optional build macro: BTN_RELEASE_EVENTS_EN (adds release events with rel=1).
module button_event_queue
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        red_button,
  input  logic        blue_button,
  input  logic        green_button,
  input  logic        yellow_button,
  input  logic        poll,
  output logic [31:0] read_data,
  output logic        overflow
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
`ifdef BTN_RELEASE_EVENTS_EN
  localparam int unsigned NPEND = 8;
`else
  localparam int unsigned NPEND = 4;
`endif

  logic [3:0] raw_bits;
  logic [3:0] stable_bits;
  logic [3:0] rise_bits;
  logic [3:0] fall_bits;

  assign raw_bits = {yellow_button, green_button, blue_button, red_button};

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_red (
    .clock(clock), .reset(reset), .button(raw_bits[0]),
    .stable(stable_bits[0]), .rise_pulse(rise_bits[0]), .fall_pulse(fall_bits[0])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_blue (
    .clock(clock), .reset(reset), .button(raw_bits[1]),
    .stable(stable_bits[1]), .rise_pulse(rise_bits[1]), .fall_pulse(fall_bits[1])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_green (
    .clock(clock), .reset(reset), .button(raw_bits[2]),
    .stable(stable_bits[2]), .rise_pulse(rise_bits[2]), .fall_pulse(fall_bits[2])
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_yellow (
    .clock(clock), .reset(reset), .button(raw_bits[3]),
    .stable(stable_bits[3]), .rise_pulse(rise_bits[3]), .fall_pulse(fall_bits[3])
  );

  // Slots 0..3 are presses (red..yellow); slots 4..7, when built, are releases.
  logic [NPEND-1:0] set_bits;
`ifdef BTN_RELEASE_EVENTS_EN
  assign set_bits = {fall_bits, rise_bits};
  logic unused_stable;
  assign unused_stable = ^stable_bits;
`else
  assign set_bits = rise_bits;
  logic unused_levels;
  assign unused_levels = ^{stable_bits, fall_bits};
`endif

  logic [NPEND-1:0] pending;
  logic [NPEND-1:0] grant;
  btn_evt_t         push_evt;

  // Fixed-priority pick of the lowest pending slot, i.e. presses before releases.
  always_comb begin
    logic found;
    grant    = '0;
    push_evt = '0;
    found    = 1'b0;
    for (int unsigned i = 0; i < NPEND; i++) begin
      if (pending[i] && !found) begin
        found       = 1'b1;
        grant[i]    = 1'b1;
        push_evt[1:0] = colour_of(2'(i % 4));
`ifdef BTN_RELEASE_EVENTS_EN
        push_evt[2] = (i >= 4);
`endif
      end
    end
  end

  // A new edge wins over a same-cycle clear of its own slot.
  always_ff @(posedge clock) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~grant) | set_bits;
  end

  btn_evt_t         mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             poll_q;
  logic [3:0]       hold_reg;

  logic        empty;
  logic        full;
  logic        poll_rise;
  logic        want_push;
  logic        do_push;
  logic        do_pop;
  logic [31:0] head_word;

  assign empty     = (count == '0);
  assign full      = (count == (PTR_W+1)'(FIFO_DEPTH));
  assign poll_rise = poll & ~poll_q;
  assign want_push = |grant;
  assign do_pop    = poll_rise & ~empty;
  // A full FIFO still accepts when the same cycle frees an entry.
  assign do_push   = want_push & (~full | do_pop);
  assign head_word = empty ? '0 : evt_word(mem[rd_ptr]);

  // FIFO storage writes; contents need no reset since count gates every read.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_evt;
  end

  // FIFO pointers, occupancy, sticky overflow and poll edge capture.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      poll_q   <= 1'b0;
      hold_reg <= '0;
    end else begin
      poll_q <= poll;
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (want_push && !do_push) overflow <= 1'b1;
      if (poll_rise) hold_reg <= head_word[3:0];
    end
  end

  // Head on the rise cycle, held word while poll stays high, zero otherwise.
  always_comb begin
    read_data = '0;
    if (poll_rise)  read_data = head_word;
    else if (poll)  read_data = {28'd0, hold_reg};
  end

endmodule

// File: tb/tb_button_event_queue.sv
// Self-checking bench for button_event_queue (DEBOUNCE_CYCLES=4, FIFO_DEPTH=4).
// Honours BTN_RELEASE_EVENTS_EN when the same macro is given to the build.
module tb_button_event_queue;
  import btn_pkg::*;

  localparam int unsigned DB    = 4;
  localparam int unsigned DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        red_button = 1'b0, blue_button = 1'b0, green_button = 1'b0, yellow_button = 1'b0;
  logic        poll = 1'b0;
  logic [31:0] read_data;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  button_event_queue #(.DEBOUNCE_CYCLES(DB), .FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .red_button(red_button), .blue_button(blue_button),
    .green_button(green_button), .yellow_button(yellow_button),
    .poll(poll), .read_data(read_data), .overflow(overflow)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  typedef struct packed {
    logic [3:0]       btns;
    logic [7:0]       hold;
    logic             ovf;
    logic [4:0][31:0] exp;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] b, input logic [7:0] h, input logic o,
                              input logic [31:0] e0, e1, e2, e3, e4);
    vec_t v;
    v.btns = b; v.hold = h; v.ovf = o;
    v.exp[0] = e0; v.exp[1] = e1; v.exp[2] = e2; v.exp[3] = e3; v.exp[4] = e4;
    return v;
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) begin @(posedge clock); #1; end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic set_btns(input logic [3:0] b);
    {yellow_button, green_button, blue_button, red_button} = b;
  endtask

  task automatic do_reset(input int unsigned n);
    reset = 1'b1; poll = 1'b0;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] b, input int unsigned hold, input int unsigned after);
    set_btns(b);
    tick(hold);
    set_btns(4'b0000);
    tick(after);
  endtask

  // Poll high for len cycles; returns the rise-cycle word and whether it stayed constant.
  task automatic do_poll(input int unsigned len, output logic [31:0] first, output logic steady);
    poll = 1'b1;
    #1;
    first  = read_data;
    steady = 1'b1;
    for (int unsigned k = 1; k < len; k++) begin
      @(posedge clock); #1;
      if (read_data !== first) steady = 1'b0;
    end
    @(posedge clock); #1;
    poll = 1'b0;
    tick(1);
  endtask

  // Reference model: an event exists iff a button is held for at least DB cycles.
  logic [31:0] mq[$];
  logic        movf;

  task automatic model_push(input logic [31:0] w);
    if (mq.size() < DEPTH) mq.push_back(w);
    else                   movf = 1'b1;
  endtask

  function automatic logic [31:0] model_pop();
    if (mq.size() == 0) return 32'h0;
    return mq.pop_front();
  endfunction

  vec_t        vecs[7];
  logic [31:0] w;
  logic        s;
  logic [3:0]  one_hot[6];

  initial begin
`ifdef BTN_RELEASE_EVENTS_EN
    vecs[0] = mk(4'b0100, 8'd10, 1'b0, 32'h6, 32'hE, 32'h0, 32'h0, 32'h0);
    vecs[1] = mk(4'b0001, 8'd10, 1'b0, 32'h4, 32'hC, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(4'b1111, 8'd10, 1'b1, 32'h4, 32'h5, 32'h6, 32'h7, 32'h0);
    vecs[3] = mk(4'b1010, 8'd6,  1'b0, 32'h5, 32'h7, 32'hD, 32'hF, 32'h0);
    vecs[5] = mk(4'b0100, 8'd4,  1'b0, 32'h6, 32'hE, 32'h0, 32'h0, 32'h0);
`else
    vecs[0] = mk(4'b0100, 8'd10, 1'b0, 32'h6, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[1] = mk(4'b0001, 8'd10, 1'b0, 32'h4, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[2] = mk(4'b1111, 8'd10, 1'b0, 32'h4, 32'h5, 32'h6, 32'h7, 32'h0);
    vecs[3] = mk(4'b1010, 8'd6,  1'b0, 32'h5, 32'h7, 32'h0, 32'h0, 32'h0);
    vecs[5] = mk(4'b0100, 8'd4,  1'b0, 32'h6, 32'h0, 32'h0, 32'h0, 32'h0);
`endif
    vecs[4] = mk(4'b0100, 8'd3,  1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[6] = mk(4'b1000, 8'd1,  1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    // Reset state
    do_reset(2);
    check("reset read_data", read_data, 32'h0);
    check("reset overflow", {31'd0, overflow}, 32'h0);

    // Table-driven single/simultaneous/glitch presses
    for (int unsigned i = 0; i < 7; i++) begin
      do_reset(2);
      press(vecs[i].btns, int'(vecs[i].hold), 14);
      check($sformatf("vec%0d overflow", i), {31'd0, overflow}, {31'd0, vecs[i].ovf});
      for (int unsigned k = 0; k < 5; k++) begin
        do_poll(1, w, s);
        check($sformatf("vec%0d poll%0d", i, k), w, vecs[i].exp[k]);
      end
    end

    // Bounce: toggling every 2 cycles never settles, then a steady press
    do_reset(2);
    for (int unsigned t = 0; t < 20; t++) begin
      red_button = ((t / 2) % 2) == 0;
      tick(1);
    end
    red_button = 1'b1;
    tick(12);
    do_poll(1, w, s); check("bounce poll0", w, 32'h4);
    do_poll(1, w, s); check("bounce poll1", w, 32'h0);
    red_button = 1'b0;

    // Overflow: six presses with no poll
    do_reset(2);
    one_hot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
    for (int unsigned i = 0; i < 6; i++) press(one_hot[i], 6, 10);
    check("ovf flag", {31'd0, overflow}, 32'h1);
`ifdef BTN_RELEASE_EVENTS_EN
    do_poll(1, w, s); check("ovf poll0", w, 32'h4);
    do_poll(1, w, s); check("ovf poll1", w, 32'hC);
    do_poll(1, w, s); check("ovf poll2", w, 32'h5);
    do_poll(1, w, s); check("ovf poll3", w, 32'hD);
`else
    do_poll(1, w, s); check("ovf poll0", w, 32'h4);
    do_poll(1, w, s); check("ovf poll1", w, 32'h5);
    do_poll(1, w, s); check("ovf poll2", w, 32'h6);
    do_poll(1, w, s); check("ovf poll3", w, 32'h7);
`endif
    do_poll(1, w, s); check("ovf poll4", w, 32'h0);
    check("ovf sticky", {31'd0, overflow}, 32'h1);

    // Reset mid-queue with overflow still set from above
    press(4'b0101, 6, 14);
    reset = 1'b1; tick(1); reset = 1'b0;
    check("midreset overflow", {31'd0, overflow}, 32'h0);
    check("midreset idle word", read_data, 32'h0);
    do_poll(1, w, s); check("midreset poll", w, 32'h0);

    // Long poll: one pop only, word held steady
    do_reset(2);
    press(4'b0101, 6, 14);
    do_poll(5, w, s);
    check("longpoll word", w, 32'h4);
    check("longpoll steady", {31'd0, s}, 32'h1);
    check("longpoll low word", read_data, 32'h0);
    do_poll(1, w, s); check("longpoll second", w, 32'h6);

    // Press and release yellow
    do_reset(2);
    press(4'b1000, 6, 14);
    do_poll(1, w, s); check("yellow press", w, 32'h7);
`ifdef BTN_RELEASE_EVENTS_EN
    do_poll(1, w, s); check("yellow release", w, 32'hF);
`else
    do_poll(1, w, s); check("yellow release", w, 32'h0);
`endif

    // Button held through reset yields a fresh event, not an immediate one
    red_button = 1'b1;
    do_reset(3);
    do_poll(1, w, s); check("held reset early", w, 32'h0);
    tick(10);
    do_poll(1, w, s); check("held reset event", w, 32'h4);
    red_button = 1'b0;
    tick(12);

    // Randomised presses against the queue model
    do_reset(2);
    mq.delete();
    movf = 1'b0;
    for (int unsigned it = 0; it < 40; it++) begin
      logic [3:0]  mask;
      int unsigned hold;
      int unsigned npoll;
      mask = 4'($urandom_range(1, 15));
      hold = $urandom_range(1, 8);
      press(mask, hold, 14);
      if (hold >= DB) begin
        for (int unsigned c = 0; c < 4; c++)
          if (mask[c]) model_push(32'h4 | c);
`ifdef BTN_RELEASE_EVENTS_EN
        for (int unsigned c = 0; c < 4; c++)
          if (mask[c]) model_push(32'hC | c);
`endif
      end
      npoll = $urandom_range(0, 3);
      for (int unsigned p = 0; p < npoll; p++) begin
        do_poll($urandom_range(1, 3), w, s);
        check($sformatf("rand it%0d poll%0d", it, p), w, model_pop());
      end
      check($sformatf("rand it%0d overflow", it), {31'd0, overflow}, {31'd0, movf});
    end
    for (int unsigned p = 0; p < DEPTH + 1; p++) begin
      do_poll(1, w, s);
      check($sformatf("rand drain%0d", p), w, model_pop());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
